branch_predictor: RTL and testbench
===================================

# branch_predictor

Bimodal branch predictor and redirect controller for the Riscv151 pipeline. The fetch stage looks up a table of 2-bit saturating counters indexed by PC and gets a taken/not-taken prediction. When a conditional branch (beq/bne/blt/bge/bltu/bgeu) resolves in execute, the block trains the table, raises `flush` and supplies the correct `redirect_pc` on a mispredict. It also keeps saturating branch and mispredict counters, readable through the CSR/MMIO path.

## Interface
- `ENTRIES`, default 64: number of 2-bit counters; power of two, at least 2.
- `IDX_W`, default `$clog2(ENTRIES)`: index width; derived, do not override.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset); deassertion is synchronous to `clk`.
- `if_pc` in 32: PC being fetched this cycle.
- `pred_taken` out 1: combinational prediction for `if_pc`.
- `ex_valid` in 1: execute stage holds a live instruction.
- `ex_stall` in 1: execute is stalled; suppresses all updates.
- `ex_is_branch` in 1: execute instruction is a conditional branch.
- `ex_pc` in 32: PC of the execute instruction.
- `ex_taken` in 1: actual branch outcome from the comparator.
- `ex_pred` in 1: `pred_taken` value piped along with this instruction.
- `ex_target` in 32: computed branch target.
- `flush` out 1: mispredict; squash younger instructions.
- `redirect_pc` out 32: next PC to fetch when `flush` = 1.
- `br_count` out 32: resolved branches, saturating.
- `mp_count` out 32: mispredicts, saturating.

## Operation
- **Index:** `idx = pc[IDX_W+1:2]`; bits [1:0] are ignored.
- **Counter encoding:** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. `pred_taken = table[idx(if_pc)][1]`.
- **Resolve event:** `res = ex_valid & ex_is_branch & ~ex_stall`.
- **Mispredict:** `flush = res & (ex_taken != ex_pred)`.
  - `redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4`, with the add wrapping modulo 2^32.
  - `redirect_pc` is driven by this expression whenever `flush` = 1 and is don't-care otherwise; the bench checks it only under `flush`.
- **Training:** on `res`, `table[idx(ex_pc)]` increments if `ex_taken` (saturating at 11) and decrements otherwise (saturating at 00).
- **Statistics:**
  - On `res`, `br_count` increments, holding at 32'hFFFF_FFFF.
  - On `flush`, `mp_count` increments, with the same saturation.
- **Non-branches:** instructions with `ex_is_branch` = 0 (including jal/jalr) never train the table or count. Jumps are redirected by the existing PC-select logic.
- **Reset values:**
  - All counters = 01, so `pred_taken` = 0 everywhere.
  - `br_count` = `mp_count` = 0.
  - `flush` follows its inputs, so it is 0 whenever `ex_valid` = 0.
- **Reset mid-operation:** asserting `rst` discards all training and statistics immediately, asynchronously.

## Timing
- **Lookup:** zero latency. `pred_taken` is combinational from the registered table and `if_pc`.
- **flush / redirect_pc:** combinational in the resolve cycle, so fetch redirects on the next edge. This gives a one-cycle mispredict penalty beyond the squashed slots.
- **Table write:** on the rising edge that ends the resolve cycle; visible to lookups from the following cycle.
- **Same-index collision:** if `idx(if_pc) == idx(ex_pc)` in the resolve cycle, the lookup returns the pre-update value. There is no bypass.
- **ex_stall:** while high, no training, no counting and no `flush`. The branch resolves in the first cycle `ex_stall` is low.
- **Back-to-back:** a resolve every cycle is supported; each is one independent read-modify-write.

## Structure
- Shared package `riscv151_bp_pkg`:
  - counter encodings: `SNT`, `WNT`, `WT`, `ST`
  - reset value `BP_INIT` = `WNT`
  - function `bp_idx(pc)`
- One sub-module `sat_counter2`: combinational 2-bit saturating next-state from (`cur`, `taken`). The table is a register array in the top level.
- Statistics counters are inline; no separate module.
- Estimated size: about 150 lines of RTL.

## Test plan
- **Reset:** hold `rst` = 0, then release. For all 64 indices, `pred_taken` = 0; `br_count` = `mp_count` = 0.
- **Training up:** three taken resolves at `ex_pc` = 0x100 with `ex_pred` = 0.
  - Prediction for 0x100 goes 0 → 1 → 1, ending in counter 11.
  - `flush` is 1 on the first resolve only if `ex_pred` = 0. When `ex_pred` tracks the prediction, `mp_count` = 1 and `br_count` = 3.
- **Hysteresis and not-taken redirect:** train 0x100 to 11, then one not-taken resolve with `ex_pred` = 1.
  - `flush` = 1 and `redirect_pc` = 0x104.
  - The counter goes to 10, and the prediction stays 1.
- **Taken redirect, wrap and stall:**
  - `ex_pc` = 0xFFFF_FFFC, `ex_taken` = 1, `ex_pred` = 0, `ex_target` = 0x40 → `flush` = 1, `redirect_pc` = 0x40.
  - The same inputs with `ex_taken` = 0 and `ex_pred` = 1 → `redirect_pc` = 0x0000_0000.
  - With `ex_stall` = 1, `flush` = 0 and no counters change.
- **Collision and aliasing:** `if_pc` = 0x200 and `ex_pc` = 0x300 alias to index 0 with `ENTRIES` = 64. A taken resolve shows the old prediction 0 in that cycle and 1 in the next cycle. Also check that a non-branch with `ex_is_branch` = 0 changes nothing.
- **Saturation:**
  - Force `br_count` to 0xFFFF_FFFE, then three resolves → it holds at 0xFFFF_FFFF.
  - A table counter at 00 given a not-taken resolve stays at 00.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the bimodal predictor: 2-bit counter encodings, reset value, PC index helper.
// Pure declarations; no latency or backpressure of its own.
package riscv151_bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_e;

   localparam bp_ctr_e BP_INIT = WNT;

   // Word index of a PC; callers truncate to their table index width.
   function automatic logic [29:0] bp_idx(input logic [31:0] pc);
      return pc[31:2];
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing signal bundle of the branch predictor.
// Purely combinational wiring; no handshake, execute stalls via ex_stall.
interface branch_predictor_if;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic        ex_stall;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic        ex_pred;
   logic [31:0] ex_target;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] br_count;
   logic [31:0] mp_count;

   modport master (
      output if_pc, ex_valid, ex_stall, ex_is_branch, ex_pc, ex_taken, ex_pred, ex_target,
      input  pred_taken, flush, redirect_pc, br_count, mp_count
   );

   modport slave (
      input  if_pc, ex_valid, ex_stall, ex_is_branch, ex_pc, ex_taken, ex_pred, ex_target,
      output pred_taken, flush, redirect_pc, br_count, mp_count
   );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state: step toward taken/not-taken, hold at the ends.
// Combinational, zero latency; no backpressure.
module sat_counter2
   import riscv151_bp_pkg::*;
(
   input  bp_ctr_e cur,
   input  logic    taken,
   output bp_ctr_e nxt
);

   always_comb begin
      nxt = cur;
      unique case (cur)
         SNT: nxt = taken ? WNT : SNT;
         WNT: nxt = taken ? WT  : SNT;
         WT:  nxt = taken ? ST  : WNT;
         ST:  nxt = taken ? ST  : WT;
         default: nxt = cur;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal predictor + mispredict redirect: zero-latency lookup, flush/redirect combinational in resolve cycle,
// training and stats registered on the closing edge; ex_stall holds off every update.
module branch_predictor
   import riscv151_bp_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bp
);

   logic [1:0]       tbl [ENTRIES];
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   bp_ctr_e          cur_ctr;
   bp_ctr_e          nxt_ctr;
   logic             res;
   logic [31:0]      br_count_q;
   logic [31:0]      mp_count_q;

   assign if_idx  = IDX_W'(bp_idx(bp.if_pc));
   assign ex_idx  = IDX_W'(bp_idx(bp.ex_pc));
   assign cur_ctr = bp_ctr_e'(tbl[ex_idx]);

   sat_counter2 u_sat (
      .cur   (cur_ctr),
      .taken (bp.ex_taken),
      .nxt   (nxt_ctr)
   );

   // No bypass: a same-index lookup in the resolve cycle sees the pre-update counter.
   assign bp.pred_taken  = tbl[if_idx][1];

   assign res            = bp.ex_valid & bp.ex_is_branch & ~bp.ex_stall;
   assign bp.flush       = res & (bp.ex_taken != bp.ex_pred);
   assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i] <= BP_INIT;
         end
      end else if (res) begin
         tbl[ex_idx] <= nxt_ctr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         br_count_q <= '0;
         mp_count_q <= '0;
      end else begin
         if (res && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_q <= br_count_q + 32'd1;
         end
         if (bp.flush && (mp_count_q != 32'hFFFF_FFFF)) begin
            mp_count_q <= mp_count_q + 32'd1;
         end
      end
   end

   assign bp.br_count = br_count_q;
   assign bp.mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: scoreboard queue of expected values checked by immediate assertions.
module tb_branch_predictor;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_predictor_if bp ();

   branch_predictor #(.ENTRIES(64)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bp)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   logic [1:0]  m_tbl [64];
   logic [31:0] m_br;
   logic [31:0] m_mp;

   function automatic int midx(input logic [31:0] pc);
      return int'(pc[7:2]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
      m_br = 32'd0;
      m_mp = 32'd0;
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic cmp(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         vectors++;
         assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic chk_pred(input logic [31:0] pc);
      @(negedge clk);
      bp.if_pc = pc;
      push("pred_taken", {31'd0, m_tbl[midx(pc)][1]});
      #1;
      cmp({31'd0, bp.pred_taken});
   endtask

   task automatic resolve(input logic [31:0] pc, input logic t, input logic p,
                          input logic [31:0] tgt, input logic st, input logic isbr,
                          input logic v);
      logic r;
      logic f;
      int   k;
      @(negedge clk);
      bp.ex_valid     = v;
      bp.ex_stall     = st;
      bp.ex_is_branch = isbr;
      bp.ex_pc        = pc;
      bp.ex_taken     = t;
      bp.ex_pred      = p;
      bp.ex_target    = tgt;
      r = v & isbr & ~st;
      f = r & (t != p);
      push("pred_in_resolve", {31'd0, m_tbl[midx(bp.if_pc)][1]});
      push("flush", {31'd0, f});
      if (f) push("redirect_pc", t ? tgt : pc + 32'd4);
      #1;
      cmp({31'd0, bp.pred_taken});
      cmp({31'd0, bp.flush});
      if (f) cmp(bp.redirect_pc);
      if (r) begin
         k = midx(pc);
         if (t && m_tbl[k] != 2'b11) m_tbl[k] = m_tbl[k] + 2'b01;
         if (!t && m_tbl[k] != 2'b00) m_tbl[k] = m_tbl[k] - 2'b01;
         if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
         if (f && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 32'd1;
      end
      @(posedge clk);
      #1;
      bp.ex_valid     = 1'b0;
      bp.ex_stall     = 1'b0;
      bp.ex_is_branch = 1'b0;
      push("br_count", m_br);
      push("mp_count", m_mp);
      cmp(bp.br_count);
      cmp(bp.mp_count);
   endtask

   initial begin
      rst             = 1'b0;
      bp.if_pc        = 32'd0;
      bp.ex_valid     = 1'b0;
      bp.ex_stall     = 1'b0;
      bp.ex_is_branch = 1'b0;
      bp.ex_pc        = 32'd0;
      bp.ex_taken     = 1'b0;
      bp.ex_pred      = 1'b0;
      bp.ex_target    = 32'd0;
      model_reset();

      // Reset state
      #12;
      push("rst_br_count", 32'd0);
      push("rst_mp_count", 32'd0);
      push("rst_pred", 32'd0);
      cmp(bp.br_count);
      cmp(bp.mp_count);
      cmp({31'd0, bp.pred_taken});
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 64; i++) chk_pred(32'(i * 4));

      // Training up at 0x100
      bp.if_pc = 32'h100;
      resolve(32'h100, 1'b1, 1'b0, 32'h180, 1'b0, 1'b1, 1'b1);
      chk_pred(32'h100);
      resolve(32'h100, 1'b1, 1'b1, 32'h180, 1'b0, 1'b1, 1'b1);
      chk_pred(32'h100);
      resolve(32'h100, 1'b1, 1'b1, 32'h180, 1'b0, 1'b1, 1'b1);
      chk_pred(32'h100);

      // Hysteresis and not-taken redirect to 0x104
      resolve(32'h100, 1'b0, 1'b1, 32'h180, 1'b0, 1'b1, 1'b1);
      chk_pred(32'h100);

      // Taken redirect, wrap of pc+4
      resolve(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h40, 1'b0, 1'b1, 1'b1);
      chk_pred(32'hFFFF_FFFC);
      resolve(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
      chk_pred(32'hFFFF_FFFC);

      // Stall, invalid, non-branch: nothing changes
      resolve(32'h100, 1'b0, 1'b1, 32'h180, 1'b1, 1'b1, 1'b1);
      resolve(32'h100, 1'b0, 1'b1, 32'h180, 1'b0, 1'b1, 1'b0);
      resolve(32'h100, 1'b0, 1'b1, 32'h180, 1'b0, 1'b0, 1'b1);
      chk_pred(32'h100);

      // Asynchronous reset mid-operation, observed before the next edge
      @(negedge clk);
      bp.if_pc = 32'h100;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      push("async_rst_pred", 32'd0);
      push("async_rst_br", 32'd0);
      push("async_rst_mp", 32'd0);
      cmp({31'd0, bp.pred_taken});
      cmp(bp.br_count);
      cmp(bp.mp_count);
      @(negedge clk);
      rst = 1'b1;

      // Collision: 0x200 and 0x300 both map to index 0
      bp.if_pc = 32'h200;
      resolve(32'h300, 1'b1, 1'b0, 32'h500, 1'b0, 1'b1, 1'b1);
      chk_pred(32'h200);

      // Saturation at 00
      resolve(32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      resolve(32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk_pred(32'h8);
      resolve(32'h8, 1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 1'b1);
      chk_pred(32'h8);
      resolve(32'h8, 1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 1'b1);
      chk_pred(32'h8);

      // br_count saturation
      @(negedge clk);
      force dut.br_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.br_count_q;
      m_br = 32'hFFFF_FFFE;
      push("br_preload", 32'hFFFF_FFFE);
      cmp(bp.br_count);
      for (int i = 0; i < 3; i++) resolve(32'h10, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);

      if (exp_q.size() != 0) begin
         miscompares++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
